// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32I-style core: sequences fetch, decode,
// execute, memory and write-back, counts retired instructions and latches sticky errors.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ist_i,
  input  logic        mem_ack_i,
  input  logic        br_take_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic [1:0]  alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o,
  output logic        illegal_o,
  output logic        bus_err_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_II    = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_UJ    = 7'b1101111;
  localparam logic [6:0] OP_IJ    = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] A_RS1    = 2'd0;
  localparam logic [1:0] A_PC     = 2'd1;
  localparam logic [1:0] A_ZERO   = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_II, C_LOAD, C_STORE, C_SB, C_UJ, C_IJ, C_LUI, C_AUIPC, C_ILL
  } iclass_t;

  state_t            state_q, state_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              run_q, run_d;
  logic [31:0]       instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  iclass_t           iclass;
  logic              req_active;
  logic              req_expire;
  logic [1:0]        exec_a_sel;
  logic              exec_b_sel;
  logic [1:0]        wb_src;
  logic [1:0]        done_pc_sel;
  logic              unused_ist_bits;

  // Only the opcode field steers the sequencer; the rest belongs to the datapath.
  assign unused_ist_bits = ^ist_i[31:7];

  always_comb begin : decode
    case (opcode_q)
      OP_R:     iclass = C_R;
      OP_II:    iclass = C_II;
      OP_LOAD:  iclass = C_LOAD;
      OP_STORE: iclass = C_STORE;
      OP_SB:    iclass = C_SB;
      OP_UJ:    iclass = C_UJ;
      OP_IJ:    iclass = C_IJ;
      OP_LUI:   iclass = C_LUI;
      OP_AUIPC: iclass = C_AUIPC;
      default:  iclass = C_ILL;
    endcase
  end

  always_comb begin : class_selects
    exec_a_sel  = A_RS1;
    exec_b_sel  = 1'b0;
    wb_src      = WB_ALU;
    done_pc_sel = PC_SEQ;
    case (iclass)
      C_II, C_STORE: exec_b_sel = 1'b1;
      C_LOAD: begin
        exec_b_sel = 1'b1;
        wb_src     = WB_MEM;
      end
      C_IJ: begin
        exec_b_sel  = 1'b1;
        wb_src      = WB_LINK;
        done_pc_sel = PC_ALU;
      end
      C_UJ: begin
        exec_a_sel  = A_PC;
        exec_b_sel  = 1'b1;
        wb_src      = WB_LINK;
        done_pc_sel = PC_IMM;
      end
      C_AUIPC: begin
        exec_a_sel = A_PC;
        exec_b_sel = 1'b1;
      end
      C_LUI: begin
        exec_a_sel = A_ZERO;
        exec_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // run_q holds off the first fetch request until one edge after reset release.
  assign req_active = ((state_q == S_FETCH) && run_q) || (state_q == S_MEM);
  assign req_expire = req_active && !mem_ack_i && (wait_q == WAIT_LAST);

  always_comb begin : wait_count
    wait_d = '0;
    if (req_active && !mem_ack_i && !req_expire) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin : fsm
    state_d     = state_q;
    opcode_d    = opcode_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    mem_req_o   = req_active;
    mem_we_o    = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = PC_SEQ;
    alu_a_sel_o = A_RS1;
    alu_b_sel_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = WB_ALU;
    case (state_q)
      S_FETCH: begin
        if (req_active) begin
          if (mem_ack_i) begin
            ir_we_o  = 1'b1;
            opcode_d = ist_i[6:0];
            state_d  = S_DECODE;
          end else if (req_expire) begin
            bus_err_d = 1'b1;
            state_d   = S_ERR;
          end
        end
      end
      S_DECODE: begin
        if (iclass == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = S_ERR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel_o = exec_a_sel;
        alu_b_sel_o = exec_b_sel;
        case (iclass)
          C_SB: begin
            pc_we_o  = 1'b1;
            pc_sel_o = br_take_i ? PC_IMM : PC_SEQ;
            state_d  = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_we_o = (iclass == C_STORE);
        if (mem_ack_i) begin
          if (iclass == C_STORE) begin
            pc_we_o = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (req_expire) begin
          bus_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        wb_sel_o = wb_src;
        pc_sel_o = done_pc_sel;
        state_d  = S_FETCH;
      end
      S_ERR: ;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin : retire
    instret_d = instret_q;
    if (pc_we_o) begin
      instret_d = instret_q + 32'd1;
    end
  end

  assign run_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      run_q     <= 1'b0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      run_q     <= run_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;

endmodule
